exe_stage_unit: RTL and testbench

Execute-stage consumer of the ID-stage control bundle (alu_command, mem_read, mem_write, wb_en, branch, status_en).
- Holds the ID/EX pipeline register (stall/flush handshake) and performs the ALU operation.
- Owns the NZCV status register and resolves branches.
- Sits between the ID stage and the EX/MEM register.

---
 rtl/arm_pkg.sv | 75 +++++++
 rtl/exe_alu.sv | 66 ++++++
 rtl/exe_stage_unit.sv | 139 +++++++++++++
 tb/tb_exe_stage_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ALU command, NZCV flag index and condition code definitions
// for the execute stage.
package arm_pkg;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_command;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       status_en;
  } ctrl_t;

  function automatic logic cond_pass(
    input logic [3:0] cond,
    input logic [3:0] f
  );
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c & !z;
      COND_LS: cond_pass = !c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU: one adder serves ADD/ADC/SUB/SBC by inverting B,
// so C is carry-out for adds and NOT-borrow for subtracts.
module exe_alu
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_cmd,
  input  logic [3:0]       i_flags,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_arith;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_b      = i_b;
    w_cin    = 1'b0;
    w_arith  = 1'b0;
    o_result = '0;
    case (i_cmd)
      ALU_MOV: o_result = i_b;
      ALU_MVN: o_result = ~i_b;
      ALU_ADD: w_arith = 1'b1;
      ALU_ADC: begin
        w_arith = 1'b1;
        w_cin   = i_flags[FLAG_C];
      end
      ALU_SUB: begin
        w_arith = 1'b1;
        w_b     = ~i_b;
        w_cin   = 1'b1;
      end
      ALU_SBC: begin
        w_arith = 1'b1;
        w_b     = ~i_b;
        w_cin   = i_flags[FLAG_C];
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_ORR: o_result = i_a | i_b;
      ALU_EOR: o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
    w_sum = {1'b0, i_a} + {1'b0, w_b}
          + {{WIDTH{1'b0}}, w_cin};
    if (w_arith)
      o_result = w_sum[WIDTH-1:0];
  end

  always_comb begin
    o_flags         = i_flags;
    o_flags[FLAG_N] = o_result[WIDTH-1];
    o_flags[FLAG_Z] = (o_result == '0);
    if (w_arith) begin
      o_flags[FLAG_C] = w_sum[WIDTH];
      o_flags[FLAG_V] = (i_a[WIDTH-1] == w_b[WIDTH-1])
                      & (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: ID/EX register, ALU, NZCV status and branch resolution.
// Define COND_EXEC_EN to enable ARM conditional execution on id_cond.
module exe_stage_unit
  import arm_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [3:0]            id_alu_command,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_wb_en,
  input  logic                  id_branch,
  input  logic                  id_status_en,
  input  logic [WIDTH-1:0]      id_val_rn,
  input  logic [WIDTH-1:0]      id_val2,
  input  logic [WIDTH-1:0]      id_val_rm,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [WIDTH-1:0]      id_pc,
  input  logic [23:0]           id_imm24,
  input  logic [3:0]            id_cond,
  output logic                  ex_valid,
  output logic [WIDTH-1:0]      ex_alu_result,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_en,
  output logic [WIDTH-1:0]      ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  branch_taken,
  output logic [WIDTH-1:0]      branch_address,
  output logic [3:0]            status
);

  logic                  r_valid;
  ctrl_t                 r_ctrl;
  logic [WIDTH-1:0]      r_val_rn;
  logic [WIDTH-1:0]      r_val2;
  logic [WIDTH-1:0]      r_val_rm;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [WIDTH-1:0]      r_pc;
  logic [23:0]           r_imm24;
  logic [3:0]            r_status;

  ctrl_t                 w_id_ctrl;
  logic                  w_pass;
  logic                  w_live;
  logic                  w_status_we;
  logic [3:0]            w_flags;
  logic [WIDTH-1:0]      w_offset;

  always_comb begin
    w_id_ctrl             = '0;
    w_id_ctrl.alu_command = id_alu_command;
    w_id_ctrl.mem_read    = id_mem_read;
    w_id_ctrl.mem_write   = id_mem_write;
    w_id_ctrl.wb_en       = id_wb_en;
    w_id_ctrl.branch      = id_branch;
    w_id_ctrl.status_en   = id_status_en;
  end

`ifdef COND_EXEC_EN
  logic [3:0] r_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cond <= '0;
    else if (!flush && !stall)
      r_cond <= id_cond;
  end

  assign w_pass = cond_pass(r_cond, r_status);
`else
  logic w_unused_cond;
  assign w_unused_cond = ^id_cond;
  assign w_pass        = 1'b1;
`endif

  assign w_live      = r_valid & w_pass;
  // Status commits only as the instruction leaves EX, so a stall defers it.
  assign w_status_we = w_live & r_ctrl.status_en & !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_val_rn <= '0;
      r_val2   <= '0;
      r_val_rm <= '0;
      r_dest   <= '0;
      r_pc     <= '0;
      r_imm24  <= '0;
      r_status <= '0;
    end else begin
      if (w_status_we)
        r_status <= w_flags;
      if (flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else if (!stall) begin
        r_valid  <= id_valid;
        r_ctrl   <= id_valid ? w_id_ctrl : '0;
        r_val_rn <= id_val_rn;
        r_val2   <= id_val2;
        r_val_rm <= id_val_rm;
        r_dest   <= id_dest;
        r_pc     <= id_pc;
        r_imm24  <= id_imm24;
      end
    end
  end

  exe_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (r_val_rn),
    .i_b      (r_val2),
    .i_cmd    (r_ctrl.alu_command),
    .i_flags  (r_status),
    .o_result (ex_alu_result),
    .o_flags  (w_flags)
  );

  assign w_offset = {{(WIDTH-26){r_imm24[23]}},
                     r_imm24, 2'b00};

  assign ex_valid       = w_live;
  assign ex_mem_read    = w_live & r_ctrl.mem_read;
  assign ex_mem_write   = w_live & r_ctrl.mem_write;
  assign ex_wb_en       = w_live & r_ctrl.wb_en;
  assign ex_store_data  = r_val_rm;
  assign ex_dest        = r_dest;
  assign branch_taken   = w_live & r_ctrl.branch;
  assign branch_address = r_pc + w_offset;
  assign status         = r_status;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Scoreboard bench for exe_stage_unit: directed scenarios plus random
// traffic checked against an arithmetic reference model.
module tb_exe_stage_unit;
  import arm_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_alu_command = '0;
  logic        id_mem_read = 1'b0;
  logic        id_mem_write = 1'b0;
  logic        id_wb_en = 1'b0;
  logic        id_branch = 1'b0;
  logic        id_status_en = 1'b0;
  logic [31:0] id_val_rn = '0;
  logic [31:0] id_val2 = '0;
  logic [31:0] id_val_rm = '0;
  logic [3:0]  id_dest = '0;
  logic [31:0] id_pc = '0;
  logic [23:0] id_imm24 = '0;
  logic [3:0]  id_cond = '0;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_en;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_dest;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status;

  exe_stage_unit #(.WIDTH(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_command(id_alu_command),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_wb_en(id_wb_en), .id_branch(id_branch),
    .id_status_en(id_status_en), .id_val_rn(id_val_rn),
    .id_val2(id_val2), .id_val_rm(id_val_rm),
    .id_dest(id_dest), .id_pc(id_pc), .id_imm24(id_imm24),
    .id_cond(id_cond), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .branch_taken(branch_taken),
    .branch_address(branch_address), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        mr, mw, wb, br, se;
    logic [31:0] rn, v2, rm;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [23:0] imm;
    logic [3:0]  cond;
  } ins_t;

  typedef struct packed {
    logic        chk_res;
    logic [31:0] res;
    logic        mr, mw, wb, bt;
    logic [31:0] sd;
    logic [3:0]  dest;
    logic [31:0] ba;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [3:0]  m_status = '0;
  logic        m_live = 1'b0;
  logic        m_se = 1'b0;
  logic [3:0]  m_nzcv = '0;
  logic [31:0] seq = 32'd1;
  logic [31:0] last_sd = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void ref_exec(input ins_t i,
      input logic [3:0] st, output logic [31:0] res,
      output logic [3:0] f);
    longint ua, ub, sa, sb_, ci, u, s;
    logic c, v;
    bit ar;
    ua = longint'(i.rn);
    ub = longint'(i.v2);
    sa = longint'($signed(i.rn));
    sb_ = longint'($signed(i.v2));
    ci = longint'(st[1]);
    c = st[1];
    v = st[0];
    ar = 1'b0;
    u = 0;
    s = 0;
    res = '0;
    case (i.cmd)
      ALU_MOV: res = i.v2;
      ALU_MVN: res = ~i.v2;
      ALU_AND: res = i.rn & i.v2;
      ALU_ORR: res = i.rn | i.v2;
      ALU_EOR: res = i.rn ^ i.v2;
      ALU_ADD: begin
        ar = 1'b1; u = ua + ub; s = sa + sb_;
        c = (u >= 64'sd4294967296);
      end
      ALU_ADC: begin
        ar = 1'b1; u = ua + ub + ci; s = sa + sb_ + ci;
        c = (u >= 64'sd4294967296);
      end
      ALU_SUB: begin
        ar = 1'b1; u = ua - ub; s = sa - sb_;
        c = (u >= 0);
      end
      ALU_SBC: begin
        ar = 1'b1; u = ua - ub - (1 - ci);
        s = sa - sb_ - (1 - ci);
        c = (u >= 0);
      end
      default: res = '0;
    endcase
    if (ar) begin
      res = u[31:0];
      v = (s > SMAX) || (s < SMIN);
    end
    f = {res[31], res == 32'd0, c, v};
  endfunction

  function automatic bit cond_ok(input logic [3:0] cd,
                                 input logic [3:0] s);
    bit n, z, c, v;
    {n, z, c, v} = s;
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_edge(input ins_t i,
      input bit st, input bit fl);
    logic [31:0] res;
    logic [3:0]  f;
    bit pass;
    exp_t e;
    if (!st && m_live && m_se)
      m_status = m_nzcv;
    if (fl) begin
      m_live = 1'b0;
    end else if (!st) begin
      m_live = 1'b0;
      if (i.valid) begin
        ref_exec(i, m_status, res, f);
        pass = 1'b1;
`ifdef COND_EXEC_EN
        pass = cond_ok(i.cond, m_status);
`endif
        m_live = pass;
        m_se = i.se;
        m_nzcv = f;
        if (pass) begin
          e.chk_res = !i.br;
          e.res = res;
          e.mr = i.mr;
          e.mw = i.mw;
          e.wb = i.wb;
          e.bt = i.br;
          e.sd = i.rm;
          e.dest = i.dest;
          e.ba = i.pc + 32'(longint'($signed(i.imm)) * 4);
          sb.push_back(e);
        end
      end
    end
  endfunction

  // Drive at a negedge, commit at posedge, return at the next negedge.
  task automatic step(input ins_t i, input bit st = 1'b0,
                      input bit fl = 1'b0);
    i.rm = seq;
    seq++;
    id_valid = i.valid;
    id_alu_command = i.cmd;
    id_mem_read = i.mr;
    id_mem_write = i.mw;
    id_wb_en = i.wb;
    id_branch = i.br;
    id_status_en = i.se;
    id_val_rn = i.rn;
    id_val2 = i.v2;
    id_val_rm = i.rm;
    id_dest = i.dest;
    id_pc = i.pc;
    id_imm24 = i.imm;
    id_cond = i.cond;
    stall = st;
    flush = fl;
    @(posedge clk);
    model_edge(i, st, fl);
    @(negedge clk);
  endtask

  function automatic ins_t op(input logic [3:0] cmd,
      input logic [31:0] a, input logic [31:0] b,
      input logic se);
    ins_t i;
    i = '0;
    i.valid = 1'b1;
    i.cmd = cmd;
    i.rn = a;
    i.v2 = b;
    i.se = se;
    i.cond = COND_AL;
    return i;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("status", status, m_status);
      if (ex_valid && ex_store_data !== last_sd) begin
        last_sd = ex_store_data;
        if (sb.size() == 0) begin
          chk("unexpected_valid", ex_store_data, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("store_data", ex_store_data, e.sd);
          if (e.chk_res)
            chk("alu_result", ex_alu_result, e.res);
          chk("ctrl", {ex_mem_read, ex_mem_write,
                       ex_wb_en, branch_taken},
                      {e.mr, e.mw, e.wb, e.bt});
          chk("dest", ex_dest, e.dest);
          chk("branch_addr", branch_address, e.ba);
        end
      end
    end
  end

  initial begin
    ins_t i;
    @(negedge clk);
    chk("rst_valid", ex_valid, 0);
    chk("rst_result", ex_alu_result, 0);
    chk("rst_ctrl", {ex_mem_read, ex_mem_write, ex_wb_en,
                     branch_taken}, 0);
    chk("rst_baddr", branch_address, 0);
    chk("rst_status", status, 0);
    rst = 1'b0;

    // Reset while an ADD with status_en sits in EX
    step(op(ALU_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", ex_valid, 0);
    chk("midrst_result", ex_alu_result, 0);
    chk("midrst_status", status, 0);
    sb.delete();
    m_live = 1'b0;
    m_status = '0;
    last_sd = '0;
    @(negedge clk);
    rst = 1'b0;
    step('0);
    chk("postrst_status", status, 0);

    // MOV 0 then SUB 5-5
    step(op(ALU_MOV, 32'h0, 32'h0, 1'b1));
    step(op(ALU_SUB, 32'd5, 32'd5, 1'b1));
    chk("sub55_res", ex_alu_result, 0);
    step('0);
    chk("sub55_status", status, 4'b0110);

    // Signed overflow then ADC with C=0
    step(op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1));
    chk("ovf_res", ex_alu_result, 32'h8000_0000);
    step(op(ALU_ADC, 32'h0, 32'h0, 1'b1));
    chk("ovf_status", status, 4'b1001);
    chk("adc_res", ex_alu_result, 0);
    step('0);
    chk("adc_status", status, 4'b0100);

    // SUB 3-5 stalled three cycles
    step(op(ALU_SUB, 32'd3, 32'd5, 1'b1));
    for (int k = 0; k < 3; k++) begin
      step(op(ALU_ADD, 32'd1, 32'd1, 1'b1), 1'b1);
      chk("stall_status", status, 4'b0100);
    end
    chk("stall_res", ex_alu_result, 32'hFFFF_FFFE);
    step('0);
    chk("sub35_status", status, 4'b1000);

    // Wrap: all-ones plus one
    step(op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1));
    chk("wrap_res", ex_alu_result, 0);
    step('0);
    chk("wrap_status", status, 4'b0110);

    // Backward branch then flush
    i = op(4'b0000, 0, 0, 1'b0);
    i.br = 1'b1;
    i.wb = 1'b1;
    i.pc = 32'h100;
    i.imm = 24'hFF_FFFE;
    step(i);
    chk("br_taken", branch_taken, 1);
    chk("br_addr", branch_address, 32'hF8);
    i = op(ALU_MOV, 0, 32'h55, 1'b0);
    i.wb = 1'b1;
    i.mr = 1'b1;
    step(i, 1'b0, 1'b1);
    chk("flush_valid", ex_valid, 0);
    chk("flush_ctrl", {ex_mem_read, ex_mem_write, ex_wb_en,
                       branch_taken}, 0);

    // Conditional ADD after CMP 4,4
    step(op(ALU_SUB, 32'd4, 32'd4, 1'b1));
    i = op(ALU_ADD, 32'd1, 32'd2, 1'b0);
    i.wb = 1'b1;
    i.cond = COND_NE;
    step(i);
`ifdef COND_EXEC_EN
    chk("ne_wb", ex_wb_en, 0);
    chk("ne_valid", ex_valid, 0);
`else
    chk("ne_wb", ex_wb_en, 1);
    chk("ne_valid", ex_valid, 1);
`endif
    i.cond = COND_EQ;
    step(i);
    chk("eq_wb", ex_wb_en, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      i = '0;
      i.valid = ($urandom_range(0, 99) < 85);
      i.cmd = 4'($urandom_range(0, 15));
      i.mr = 1'($urandom);
      i.mw = 1'($urandom);
      i.wb = 1'($urandom);
      i.br = ($urandom_range(0, 99) < 15);
      i.se = 1'($urandom);
      i.rn = rand_val();
      i.v2 = rand_val();
      i.dest = 4'($urandom);
      i.pc = $urandom;
      i.imm = 24'($urandom);
      i.cond = ($urandom_range(0, 1) == 0) ? COND_AL
                                           : 4'($urandom);
      step(i, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 10);
    end
    for (int n = 0; n < 3; n++)
      step('0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
